// File: rtl/recog_sequencer.sv
// Control sequencer for the "Wc7" keyboard recognizer: feeds characters into the
// external history datapath, judges entries on Enter and enforces a fail lockout.
module recog_sequencer #(
    parameter int         PATTERN_LEN = 3,
    parameter int         MAX_FAILS   = 3,
    parameter int         LOCK_CYCLES = 16,
    parameter logic [6:0] ENTER_CODE  = 7'h0A,
    localparam int        FCW         = $clog2(MAX_FAILS + 1),
    localparam int        LCW         = $clog2(LOCK_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [6:0]     in_ascii,
    output logic           in_ready,
    output logic [6:0]     rec_ascii,
    output logic           rec_shift,
    output logic           rec_clear,
    input  logic           rec_match,
    output logic           pass,
    output logic           fail,
    output logic           locked,
    output logic [FCW-1:0] fail_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        CHECK  = 3'd2,
        RESULT = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [2:0] PLEN = 3'(PATTERN_LEN);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_count;
    logic [6:0]     r_rec_ascii;
    logic           r_rec_shift;
    logic           r_rec_clear;
    logic           r_pass;
    logic           r_fail;
    logic           r_locked;
    logic [FCW-1:0] r_fail_cnt;
    logic [LCW-1:0] r_lock_cnt;
    logic           w_take;
    logic           w_enter;
    logic           w_verdict;

    assign in_ready  = (r_state == IDLE);
    assign w_take    = in_valid && (r_state == IDLE);
    assign w_enter   = (in_ascii == ENTER_CODE);
    // Wrong-length entries fail even when the recognizer reports a match.
    assign w_verdict = rec_match && (r_count == PLEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    if (!w_enter) begin
                        w_state_nxt = SHIFT;
                    end else if (r_count != 3'd0) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            SHIFT:  w_state_nxt = IDLE;
            CHECK:  w_state_nxt = RESULT;
            RESULT: begin
                if (r_fail && (r_fail_cnt == FCW'(MAX_FAILS))) begin
                    w_state_nxt = LOCKED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED: begin
                if (r_lock_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so each is high exactly
    // while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_ascii <= '0;
            r_rec_shift <= 1'b0;
            r_rec_clear <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_locked    <= 1'b0;
            r_fail_cnt  <= '0;
            r_count     <= '0;
            r_lock_cnt  <= '0;
        end else begin
            r_rec_shift <= (w_state_nxt == SHIFT);
            r_rec_clear <= (w_state_nxt == RESULT);
            r_locked    <= (w_state_nxt == LOCKED);
            r_pass      <= (r_state == CHECK) && w_verdict;
            r_fail      <= (r_state == CHECK) && !w_verdict;

            if (w_take && !w_enter) begin
                r_rec_ascii <= in_ascii;
                if (r_count != 3'd7) begin
                    r_count <= r_count + 3'd1;
                end
            end else if (r_state == RESULT) begin
                r_count <= '0;
            end

            if (r_state == CHECK) begin
                r_fail_cnt <= w_verdict ? '0 : r_fail_cnt + FCW'(1);
            end else if ((r_state == LOCKED) && (r_lock_cnt == '0)) begin
                r_fail_cnt <= '0;
            end

            if (r_state == RESULT) begin
                r_lock_cnt <= LCW'(LOCK_CYCLES - 1);
            end else if ((r_state == LOCKED) && (r_lock_cnt != '0)) begin
                r_lock_cnt <= r_lock_cnt - LCW'(1);
            end
        end
    end

    assign rec_ascii = r_rec_ascii;
    assign rec_shift = r_rec_shift;
    assign rec_clear = r_rec_clear;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign locked    = r_locked;
    assign fail_cnt  = r_fail_cnt;

endmodule

// File: doc/recog_sequencer.md
# recog_sequencer

Controller for the "Wc7" keyboard sequence recognizer datapath: accepts ASCII characters from the keyboard source over a valid/ready handshake, and issues one shift per character into the recognizer. On the Enter key it samples the recognizer's match output and reports pass or fail, then flushes the recognizer history. After repeated failures it enforces a timed lockout. The recognizer's 7-bit by 3-deep history shift datapath and match logic stay outside this block; this block drives its shift and clear controls.

## Interface
- PATTERN_LEN, 3, exact number of characters an entry must contain to pass
- MAX_FAILS, 3, consecutive failed entries that trigger lockout (>=1)
- LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)
- ENTER_CODE, 7'h0A, ASCII code terminating an entry
- clk  input  1  single clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  keyboard character available
- in_ascii  input  7  keyboard character
- in_ready  output  1  block accepts in_ascii this cycle
- rec_ascii  output  7  character presented to recognizer datapath
- rec_shift  output  1  one-cycle shift enable to recognizer
- rec_clear  output  1  one-cycle synchronous clear of recognizer history
- rec_match  input  1  recognizer match (valid 1 cycle after a shift edge)
- pass  output  1  one-cycle pulse: entry accepted
- fail  output  1  one-cycle pulse: entry rejected
- locked  output  1  high throughout lockout
- fail_cnt  output  clog2(MAX_FAILS+1)  consecutive failures since last pass or lockout end

## Operation
- States: IDLE, SHIFT, CHECK, RESULT, LOCKED. Reset state is IDLE.
- Reset values: rec_ascii=0, rec_shift=0, rec_clear=0, pass=0, fail=0, locked=0, fail_cnt=0, char count=0. in_ready=1 once in IDLE, but it is ignored while rst_n is low.
- in_ready=1 only in IDLE. A character is consumed when in_valid && in_ready. If in_valid is high while in_ready=0, the source holds the data and nothing is consumed.
- IDLE, non-Enter character consumed:
  - rec_ascii is loaded with the character.
  - The block goes to SHIFT.
  - char count increments and saturates at 7.
- SHIFT: rec_shift=1 for exactly one cycle, then the block returns to IDLE.
- IDLE, ENTER_CODE consumed with count=0: ignored. No verdict, no clear, and the block stays in IDLE.
- IDLE, ENTER_CODE consumed with count>0: the block goes to CHECK. The Enter code is never shifted into the recognizer.
- CHECK: registers the verdict = rec_match && (count == PATTERN_LEN), then goes to RESULT. Entries longer or shorter than PATTERN_LEN fail even if rec_match=1.
- RESULT (one cycle):
  - pass or fail pulses and rec_clear=1; count resets to 0.
  - On pass: fail_cnt becomes 0 and the block goes to IDLE.
  - On fail: fail_cnt increments. If the new value equals MAX_FAILS, the block goes to LOCKED; otherwise it goes to IDLE.
- LOCKED: locked=1, in_ready=0, and a down-counter runs for LOCK_CYCLES cycles. On expiry, fail_cnt is cleared and the block goes to IDLE.
- rec_shift and rec_clear are never high in the same cycle. pass and fail are never high in the same cycle.
- Reset mid-operation returns to IDLE immediately and discards any partial entry. rec_clear is not pulsed, so the datapath reset clears its own history.

## Timing
- All outputs are registered, except in_ready, which decodes state.
- Character consumed at edge T: rec_ascii is valid and rec_shift=1 during cycle T+1. The recognizer captures at edge T+2. in_ready is back to 1 in cycle T+2.
- Maximum character rate is one per 2 cycles.
- Enter consumed at edge T: CHECK during cycle T+1. rec_match is sampled at edge T+2, at least one cycle after the last shift edge. pass/fail/rec_clear are high during cycle T+2. IDLE or LOCKED from cycle T+3.
- Lockout: locked is high from cycle T+3 through T+2+LOCK_CYCLES. in_ready=1 at T+3+LOCK_CYCLES.

## Test plan
- Reset, then feed 'W'(57),'c'(63),'7'(37),0A with a recognizer model:
  - exactly three rec_shift pulses, with rec_ascii=57,63,37;
  - pass=1 for one cycle, with rec_clear in the same cycle;
  - fail_cnt=0.
- Feed "Wc8"+0A: fail pulse, fail_cnt=1, rec_clear pulse, return to IDLE with in_ready=1.
- Feed "xWc7"+0A while rec_match=1: fail, because count=4 != PATTERN_LEN.
- Feed 0A alone: no pass, fail, rec_clear or shift, and state stays IDLE.
- Lockout with default parameters:
  - three consecutive wrong entries: third fail pulse, then locked=1 and in_ready=0 for 16 cycles while in_valid is held high;
  - afterwards locked=0, fail_cnt=0, and the held character is consumed.
- Assert rst_n low during SHIFT and during LOCKED:
  - all outputs go to reset values asynchronously;
  - after release, "Wc7"+0A passes.
